// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with run/hold/done control and a registered terminal-count pulse.
// Define DOWN_COUNTER_TIMER_AUTORELOAD_EN to make RUN reload from the last loaded value instead of stopping at zero.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldvalue,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] count;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    // Only the auto-reload build ever reads the reload value back.
    logic [WIDTH-1:0] reload_q;
`endif

    // Priority: rst > ld > start > pause > count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else if (ld) begin
            state <= IDLE;
            count <= ldvalue;
            tc    <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload_q <= ldvalue;
`endif
        end else if (start && (state == IDLE || state == DONE)) begin
            if (count == '0) begin
                state <= DONE;
                tc    <= 1'b1;
            end else begin
                state <= RUN;
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (pause) begin
                        state <= HOLD;
                    end else if (count != '0) begin
                        count <= count - ONE;
                        tc    <= (count == ONE);
                    end else begin
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                        count <= reload_q;
`else
                        state <= DONE;
`endif
                    end
                end
                HOLD: begin
                    // Resuming costs one cycle with no decrement.
                    if (!pause) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign dout = count;
    assign busy = (state == RUN) || (state == HOLD);
    assign done = (state == DONE);

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the count, load value and reload register.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ld  input  1  load strobe; copies ldvalue into count and reload register.
REQ-005 ldvalue  input  WIDTH  value captured on ld.
REQ-006 start  input  1  begins a countdown from the current count.
REQ-007 pause  input  1  level; freezes an active countdown while high.
REQ-008 dout  output  WIDTH  current count, driven directly from the count register.
REQ-009 busy  output  1  high in RUN or HOLD.
REQ-010 tc  output  1  terminal-count pulse, one cycle, registered.
REQ-011 done  output  1  high in DONE.

Function
REQ-012 The block SHALL implement a registered FSM with states IDLE, RUN, HOLD and DONE; all outputs are registered or decoded from state only.
REQ-013 Priority per cycle SHALL be rst > ld > start > pause > count.
REQ-014 ld in any state SHALL set count and reload_q to ldvalue, set state to IDLE, clear tc, and abort any countdown.
REQ-015 start in IDLE or DONE with count != 0 SHALL enter RUN, and the first decrement SHALL occur on the following cycle.
REQ-016 start in IDLE or DONE with count == 0 SHALL enter DONE and pulse tc for one cycle.
REQ-017 start in RUN or HOLD SHALL be ignored.
REQ-018 In RUN with pause=0 and count != 0, count SHALL decrement by 1 per cycle.
REQ-019 The cycle in which count becomes 0 SHALL also register tc=1, so tc and dout==0 are visible together.
REQ-020 RUN with pause=1 SHALL go to HOLD with no decrement that cycle.
REQ-021 HOLD SHALL keep count frozen while pause=1, and return to RUN with no decrement on the first cycle pause=0.
REQ-022 Without auto-reload, count SHALL never wrap: reaching 0 in RUN SHALL move to DONE, and DONE SHALL hold dout=0 and done=1 until ld or start.
REQ-023 tc SHALL be 0 in every cycle not named in REQ-016, REQ-019 or REQ-031.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; reload_q SHALL change only on ld or rst.

Reset
REQ-025 rst=1 at a clock edge SHALL force the following, regardless of other inputs or state:
- state IDLE
- dout = 0
- reload_q = 0
- busy = 0, tc = 0, done = 0
REQ-026 rst asserted mid-countdown SHALL abort the countdown with no tc pulse.
REQ-027 The first edge after rst deasserts SHALL obey REQ-013 normally.

Configuration
REQ-028 The macro DOWN_COUNTER_TIMER_AUTORELOAD_EN SHALL select auto-reload mode.
REQ-029 Macro undefined: behaviour per REQ-022; DONE is reachable from RUN.
REQ-030 Macro defined: RUN with count == 0 and pause=0 SHALL load count from reload_q and remain in RUN, giving a period of reload_q+1 cycles.
REQ-031 Macro defined: tc SHALL pulse on every transition of count to 0.
REQ-032 Macro defined: DONE SHALL be entered only via REQ-016 (reload_q == 0 case).
REQ-033 Port list and reset behaviour SHALL be identical in both builds.

Verification
REQ-034 Check these directed scenarios:
- rst for 2 cycles, then ld=1 with ldvalue=4'd3, then start=1 -> dout 3,3,2,1,0; tc=1 exactly with dout=0; done=1 next cycle; busy=0.
- Count 5 in RUN, pause high for 3 cycles at dout=3 -> dout holds 3 for 3 cycles plus 1 resume cycle, then 2,1,0; exactly one tc.
- ld=1 with ldvalue=4'd0, then start -> next cycle done=1, tc=1 for one cycle, dout=0.
- ld and start in the same cycle with ldvalue=4'd7 -> dout=7, state IDLE, busy=0.
- rst=1 during RUN at dout=2 -> next cycle dout=0, busy=0, tc=0, done=0; no tc afterwards.
- With AUTORELOAD_EN, ldvalue=4'd2 then start -> dout 2,1,0,2,1,0,...; tc every 3 cycles; done stays 0.
